// File: rtl/irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator.
// Register addresses and widths used by the top and the encoder.
package irq_aggregator_pkg;

   localparam int MAX_IRQ = 16;
   localparam int ID_W    = 4;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_MODE    = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
   localparam logic [2:0] ADDR_RAW     = 3'd4;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over MAX_IRQ request bits.
// Purely combinational; id is 0 when nothing is requesting.
module irq_prio_enc
   import irq_aggregator_pkg::*;
(
   input  logic [MAX_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    id_o
);

   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      // Scan downward so the lowest set index is written last.
      for (int i = MAX_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = ID_W'(i);
      end
   end

endmodule

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-line edge/level capture, mask,
// W1C pending and a registered combined irq with an active-source ID.
module irq_aggregator
   import irq_aggregator_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq
);

   logic [NUM_IRQ-1:0] raw_q;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic [15:0]        rd_d;
   logic               irq_d;

   logic               wr;
   logic [NUM_IRQ-1:0] wdat;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] w1c;
   logic [NUM_IRQ-1:0] mode_chg;
   logic [NUM_IRQ-1:0] edge_nxt;

   logic [MAX_IRQ-1:0] act_req;
   logic               act_valid;
   logic [ID_W-1:0]    act_id;
   logic [15:0]        pend_x, mask_x, mode_x, raw_x;
   logic               unused_wdata;

   assign wr           = chipselect && !write_n;
   assign wdat         = writedata[NUM_IRQ-1:0];
   assign unused_wdata = ^writedata;

   always_comb begin
      rise     = irq_in & ~raw_q;
      w1c      = '0;
      mode_chg = '0;
      if (wr && address == ADDR_PENDING) w1c = wdat;
      if (wr && address == ADDR_MODE) mode_chg = wdat ^ mode_q;
      // A rising edge beats a same-cycle W1C on edge-mode bits.
      edge_nxt = rise | (pend_q & ~w1c);
      pend_d   = ((mode_q & edge_nxt) | (~mode_q & irq_in)) & ~mode_chg;
      mask_d   = (wr && address == ADDR_MASK) ? wdat : mask_q;
      mode_d   = (wr && address == ADDR_MODE) ? wdat : mode_q;
      irq_d    = |(pend_q & mask_q);
   end

   always_comb begin
      act_req                = '0;
      act_req[NUM_IRQ-1:0]   = pend_q & mask_q;
      pend_x                 = '0;
      pend_x[NUM_IRQ-1:0]    = pend_q;
      mask_x                 = '0;
      mask_x[NUM_IRQ-1:0]    = mask_q;
      mode_x                 = '0;
      mode_x[NUM_IRQ-1:0]    = mode_q;
      raw_x                  = '0;
      raw_x[NUM_IRQ-1:0]     = raw_q;
   end

   irq_prio_enc u_prio (
      .req_i   (act_req),
      .valid_o (act_valid),
      .id_o    (act_id)
   );

   always_comb begin
      rd_d = '0;
      unique case (address)
         ADDR_PENDING: rd_d = pend_x;
         ADDR_MASK:    rd_d = mask_x;
         ADDR_MODE:    rd_d = mode_x;
         ADDR_ACTIVE:  rd_d = {act_valid, 11'b0, act_id};
         ADDR_RAW:     rd_d = raw_x;
         default:      rd_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // Sampling irq_in in reset keeps lines high at release from edging.
      raw_q <= irq_in;
      if (reset) begin
         pend_q   <= '0;
         mask_q   <= '0;
         mode_q   <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         mask_q   <= mask_d;
         mode_q   <= mode_d;
         readdata <= rd_d;
         irq      <= irq_d;
      end
   end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed and randomized bench for irq_aggregator against a
// cycle-level behavioural model of the register rules.
module tb_irq_aggregator;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [7:0]  irq_in;
   logic        irq;

   logic [3:0]  irq_in2;
   logic [15:0] readdata2;
   logic        irq2;

   int n_tot  = 0;
   int n_pass = 0;

   logic [7:0]  m_raw, m_pend, m_mask, m_mode;
   logic        m_irq;
   logic [15:0] m_rd;

   always #5 clk = ~clk;

   irq_aggregator #(.NUM_IRQ(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq        (irq)
   );

   irq_aggregator #(.NUM_IRQ(4)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata2),
      .irq_in     (irq_in2),
      .irq        (irq2)
   );

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] a);
      logic [7:0]  v;
      logic [15:0] r;
      v = m_pend & m_mask;
      r = 16'h0;
      case (a)
         3'd0: r = {8'h0, m_pend};
         3'd1: r = {8'h0, m_mask};
         3'd2: r = {8'h0, m_mode};
         3'd3: begin
            for (int i = 0; i < 8; i++) begin
               if (v[i] && r == 16'h0) r = 16'h8000 | 16'(i);
            end
         end
         3'd4: r = {8'h0, m_raw};
         default: r = 16'h0;
      endcase
      return r;
   endfunction

   task automatic model_step();
      logic [7:0]  np;
      logic        w;
      logic [15:0] nrd;
      logic        nirq;
      if (reset) begin
         m_pend = 0; m_mask = 0; m_mode = 0;
         m_irq = 0; m_rd = 0; m_raw = irq_in;
         return;
      end
      w    = chipselect && !write_n;
      nrd  = m_read(address);
      nirq = |(m_pend & m_mask);
      for (int i = 0; i < 8; i++) begin
         if (w && address == 3'd2 && writedata[i] != m_mode[i])
            np[i] = 1'b0;
         else if (m_mode[i]) begin
            if (irq_in[i] && !m_raw[i]) np[i] = 1'b1;
            else if (w && address == 3'd0 && writedata[i]) np[i] = 1'b0;
            else np[i] = m_pend[i];
         end else
            np[i] = irq_in[i];
      end
      if (w && address == 3'd1) m_mask = writedata[7:0];
      if (w && address == 3'd2) m_mode = writedata[7:0];
      m_pend = np;
      m_raw  = irq_in;
      m_rd   = nrd;
      m_irq  = nirq;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("model_rd", readdata, m_rd);
      check("model_irq", {15'h0, irq}, {15'h0, m_irq});
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      tick();
      write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 16'h0; irq_in = 8'hFF; irq_in2 = 4'h0;
      tick(); tick();
      reset = 1'b0;

      rd(3'd0);
      check("rst_pend", readdata, 16'h0);
      check("rst_irq", {15'h0, irq}, 16'h0);
      wr(3'd2, 16'h00FF);
      wr(3'd1, 16'h00FF);
      tick(); tick(); tick();
      rd(3'd0);
      check("no_spurious_edge", readdata, 16'h0);

      irq_in = 8'h00; tick();
      wr(3'd2, 16'h0001);
      wr(3'd1, 16'h0001);
      address = 3'd0;
      irq_in = 8'h01; tick();
      irq_in = 8'h00; tick();
      check("edge_pend", readdata, 16'h0001);
      check("edge_irq", {15'h0, irq}, 16'h1);
      rd(3'd3);
      check("edge_active", readdata, 16'h8000);
      wr(3'd0, 16'h0001);
      rd(3'd0);
      check("w1c_pend", readdata, 16'h0);
      check("w1c_irq", {15'h0, irq}, 16'h0);

      wr(3'd2, 16'h0000);
      irq_in = 8'h28;
      wr(3'd1, 16'h0028);
      tick();
      rd(3'd3);
      check("lvl_active3", readdata, 16'h8003);
      irq_in = 8'h20; tick();
      rd(3'd3);
      check("lvl_active5", readdata, 16'h8005);
      wr(3'd0, 16'h0028);
      rd(3'd0);
      check("lvl_w1c_ignored", readdata, 16'h0020);

      irq_in = 8'h00;
      wr(3'd2, 16'h0004);
      irq_in = 8'h04; tick();
      irq_in = 8'h00; tick();
      irq_in = 8'h04;
      wr(3'd0, 16'h0004);
      irq_in = 8'h00;
      rd(3'd0);
      check("set_beats_w1c", readdata, 16'h0004);

      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h0002);
      irq_in = 8'h02; tick();
      irq_in = 8'h00;
      rd(3'd0);
      check("masked_pend", readdata, 16'h0002);
      check("masked_irq", {15'h0, irq}, 16'h0);
      rd(3'd3);
      check("masked_active", readdata, 16'h0000);
      wr(3'd1, 16'h0002);
      tick();
      check("unmask_irq", {15'h0, irq}, 16'h1);

      wr(3'd6, 16'hFFFF);
      rd(3'd6);
      check("addr6", readdata, 16'h0);

      wr(3'd1, 16'hFFFF);
      rd(3'd1);
      check("n4_mask", readdata2, 16'h000F);

      for (int k = 0; k < 400; k++) begin
         reset      = ($urandom_range(0, 49) == 0);
         irq_in     = 8'($urandom);
         address    = 3'($urandom_range(0, 7));
         chipselect = 1'($urandom);
         write_n    = ($urandom_range(0, 3) != 0);
         writedata  = 16'($urandom);
         tick();
      end
      reset = 1'b0; write_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
